// File: rtl/mem_byte_reader_if.sv
// Word-memory read bus between the byte reader (master) and a 16-bit memory (slave).
interface mem_byte_reader_if;
    logic        mem_req;
    logic [14:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/mem_byte_reader.sv
// Reads one byte from a 16-bit word memory: request, wait for ack (with timeout),
// pick the little-endian lane, then pulse done or err for one cycle.
module mem_byte_reader #(
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [15:0]         addr,
    mem_byte_reader_if.master   mem,
    output logic [7:0]          databyte,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FIN} state_t;

    state_t          state_q, state_d;
    logic [14:0]     word_q, word_d;
    logic            lane_q, lane_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      byte_q, byte_d;
    logic            req_q, req_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        req_d   = req_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    word_d  = addr[15:1];
                    lane_d  = addr[0];
                    state_d = REQ;
                    req_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            REQ: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                // Ack wins over the timeout in the cycle the counter would reach TIMEOUT.
                if (mem.mem_ack) begin
                    byte_d  = lane_q ? mem.mem_rdata[15:8] : mem.mem_rdata[7:0];
                    state_d = FIN;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = FIN;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            lane_q  <= 1'b0;
            cnt_q   <= '0;
            byte_q  <= 8'h00;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = word_q;
    assign databyte     = byte_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
endmodule

// File: tb/tb_mem_byte_reader.sv
// Randomized self-checking bench for mem_byte_reader; expected timing and data come
// from a transaction-level model (ack delay -> done/err cycle, lane -> byte).
module tb_mem_byte_reader;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] addr;
    logic [7:0]  databyte;
    logic        busy;
    logic        done;
    logic        err;

    int          testsRun = 0;
    int          testsFailed = 0;
    logic [7:0]  expByte;

    mem_byte_reader_if bus ();

    mem_byte_reader #(.TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .addr     (addr),
        .mem      (bus),
        .databyte (databyte),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One read: ackWait is the WAIT cycle (1-based) in which ack is presented;
    // a value beyond TIMEOUT means the memory never answers in time.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] data,
                                 input int ackWait, input bit noise);
        bit         ok;
        int         endCycle;
        logic [7:0] laneByte;
        ok       = (ackWait <= TIMEOUT);
        endCycle = ok ? ackWait + 2 : TIMEOUT + 2;
        laneByte = a[0] ? data[15:8] : data[7:0];
        start         = 1'b1;
        addr          = a;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'($urandom);
        @(negedge clk);
        for (int c = 1; c <= endCycle; c++) begin
            checkOutput("busy", {31'b0, busy}, 32'd1);
            checkOutput("mem_req", {31'b0, bus.mem_req}, {31'b0, c < endCycle});
            if (c < endCycle)
                checkOutput("mem_addr", {17'b0, bus.mem_addr}, {17'b0, a[15:1]});
            checkOutput("done", {31'b0, done}, {31'b0, ok && c == endCycle});
            checkOutput("err", {31'b0, err}, {31'b0, !ok && c == endCycle});
            if (c == endCycle) begin
                if (ok) expByte = laneByte;
                checkOutput("databyte", {24'b0, databyte}, {24'b0, expByte});
            end
            if (c < endCycle) begin
                bus.mem_ack   = (c == ackWait + 1) || (noise && c == 1);
                bus.mem_rdata = (c == ackWait + 1) ? data : 16'($urandom);
            end else begin
                bus.mem_ack = 1'b0;
            end
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) addr = 16'($urandom);
            @(negedge clk);
        end
        checkOutput("idle_busy", {31'b0, busy}, 32'd0);
        checkOutput("idle_req", {31'b0, bus.mem_req}, 32'd0);
        checkOutput("idle_done", {31'b0, done}, 32'd0);
        checkOutput("idle_err", {31'b0, err}, 32'd0);
        checkOutput("idle_databyte", {24'b0, databyte}, {24'b0, expByte});
        start = 1'b0;
    endtask

    task automatic resetDuringWait(input logic [15:0] a);
        start       = 1'b1;
        addr        = a;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre_rst_req", {31'b0, bus.mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_req", {31'b0, bus.mem_req}, 32'd0);
        checkOutput("rst_addr", {17'b0, bus.mem_addr}, 32'd0);
        checkOutput("rst_databyte", {24'b0, databyte}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_err", {31'b0, err}, 32'd0);
        expByte = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        addr          = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        expByte       = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_req", {31'b0, bus.mem_req}, 32'd0);
        checkOutput("reset_databyte", {24'b0, databyte}, 32'd0);
        rst_n = 1'b1;

        applyStimulus(16'h0006, 16'hABCD, 1, 1'b0);
        applyStimulus(16'h0007, 16'hABCD, 3, 1'b0);
        applyStimulus(16'h1234, 16'h5566, TIMEOUT + 5, 1'b0);
        applyStimulus(16'h0ABC, 16'h9F31, TIMEOUT, 1'b0);
        applyStimulus(16'h0ABD, 16'h2E47, TIMEOUT + 1, 1'b0);
        applyStimulus(16'h00F2, 16'h5A3C, 2, 1'b1);
        resetDuringWait(16'hBEEF);
        applyStimulus(16'h0101, 16'h7788, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), $urandom_range(1, TIMEOUT + 3),
                          1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
